// File: rtl/elephant_spongent_seq.sv
// Multi-cycle Spongent-pi[160] permutation engine: one round per clock,
// valid/ready handshake on the input state and on the permuted result.
module elephant_spongent_seq #(
  parameter int unsigned ROUNDS    = 80,
  parameter logic [6:0]  LFSR_INIT = 7'h75
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [159:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] out_state,
  output logic         busy
);

  localparam int unsigned W   = 160;
  localparam int unsigned NIB = W / 4;
  localparam int unsigned RW  = 7;
  localparam int unsigned LW  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t          fsm;
  fsm_t          fsm_nxt;
  logic [RW-1:0] rnd;
  logic [LW-1:0] lfsr;
  logic [W-1:0]  st;
  logic          accept;
  logic          last_rnd;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'hD;
      4'h2: y = 4'hB;
      4'h3: y = 4'h0;
      4'h4: y = 4'h2;
      4'h5: y = 4'h1;
      4'h6: y = 4'h4;
      4'h7: y = 4'hF;
      4'h8: y = 4'h7;
      4'h9: y = 4'hA;
      4'hA: y = 4'h8;
      4'hB: y = 4'h5;
      4'hC: y = 4'h9;
      4'hD: y = 4'hC;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  // One full round: constant addition at both ends, S-box layer, bit permutation.
  function automatic logic [W-1:0] round_fn(input logic [W-1:0] s, input logic [LW-1:0] c);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    a = s;
    a[LW-1:0] = a[LW-1:0] ^ c;
    for (int j = 0; j < int'(LW); j++) begin
      a[W-1-j] = a[W-1-j] ^ c[j];
    end
    for (int k = 0; k < int'(NIB); k++) begin
      b[4*k +: 4] = sbox(a[4*k +: 4]);
    end
    p = '0;
    for (int i = 0; i < int'(W) - 1; i++) begin
      p[(40 * i) % (int'(W) - 1)] = b[i];
    end
    p[W-1] = b[W-1];
    return p;
  endfunction

  assign accept   = in_valid && (fsm == IDLE);
  assign last_rnd = (rnd == RW'(ROUNDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (accept)    fsm_nxt = BUSY;
      BUSY:    if (last_rnd)  fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  always_comb begin
    in_ready  = (fsm == IDLE);
    busy      = (fsm == BUSY);
    out_valid = (fsm == DONE);
    out_state = st;
  end

  // Datapath: load on accept, one round per BUSY cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= '0;
      rnd  <= '0;
      lfsr <= LFSR_INIT;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            st   <= in_state;
            lfsr <= LFSR_INIT;
            rnd  <= '0;
          end
        end
        BUSY: begin
          st   <= round_fn(st, lfsr);
          lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
          rnd  <= rnd + RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_elephant_spongent_seq.sv
// Bench for elephant_spongent_seq: scoreboard against a byte-oriented model of
// the Elephant spongent160 reference, plus handshake, latency and reset checks.
module tb_elephant_spongent_seq;

  localparam int unsigned W   = 160;
  localparam int unsigned NR  = 80;
  localparam int unsigned TMO = 400;
  localparam logic [3:0] SB [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                     4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_state;
  logic         busy;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [W-1:0] in_state1 = '0;
  logic         out_valid1;
  logic         out_ready1 = 1'b1;
  logic [W-1:0] out_state1;
  logic         busy1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  logic [W-1:0] exp_q [$];
  int           acc_q [$];
  logic         ov_prev = 1'b0;

  elephant_spongent_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  elephant_spongent_seq #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_state(out_state1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [W-1:0] player(input logic [W-1:0] s);
    logic [W-1:0] t;
    int dst;
    t = '0;
    for (int src = 0; src < 160; src++) begin
      dst = (src == 159) ? 159 : (src * 40) % 159;
      t[dst] = s[src];
    end
    return t;
  endfunction

  // Byte-array model following the C reference (state bytes, switch_bits, pLayer).
  function automatic logic [W-1:0] ref_perm(input logic [W-1:0] s, input int rounds);
    logic [7:0] st [20];
    logic [7:0] tmp [20];
    logic [7:0] lf;
    logic [7:0] rv;
    logic [W-1:0] r;
    int src;
    int dst;
    lf = 8'h75;
    for (int b = 0; b < 20; b++) st[b] = s[8*b +: 8];
    for (int rn = 0; rn < rounds; rn++) begin
      rv = 8'h00;
      for (int j = 0; j < 8; j++) rv[7-j] = lf[j];
      st[0]  = st[0] ^ lf;
      st[19] = st[19] ^ rv;
      for (int b = 0; b < 20; b++) st[b] = {SB[st[b][7:4]], SB[st[b][3:0]]};
      for (int b = 0; b < 20; b++) tmp[b] = 8'h00;
      for (int b = 0; b < 20; b++) begin
        for (int k = 0; k < 8; k++) begin
          src = 8 * b + k;
          dst = (src == 159) ? 159 : (src * 40) % 159;
          tmp[dst / 8][dst % 8] = st[b][k];
        end
      end
      st = tmp;
      lf = {1'b0, lf[5:0], lf[6] ^ lf[5]};
    end
    for (int b = 0; b < 20; b++) r[8*b +: 8] = st[b];
    return r;
  endfunction

  // Scoreboard: push on accept, check latency on out_valid rise, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_perm(in_state, NR));
        acc_q.push_back(cyc + 1);
      end
      if (out_valid && !ov_prev) begin
        if (acc_q.size() > 0) check("latency", W'(cyc - acc_q[0]), W'(NR));
        else check("spurious_out_valid", W'(1), W'(0));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check("out_state", out_state, exp_q.pop_front());
          void'(acc_q.pop_front());
          n_out++;
        end else begin
          check("unexpected_result", W'(1), W'(0));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] v, input bit keep_valid);
    int n;
    n = 0;
    in_state = v;
    in_valid = 1'b1;
    while (!in_ready && n < int'(TMO)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= int'(TMO)) check("accept_timeout", W'(0), W'(1));
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < int'(TMO)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= int'(TMO)) check("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  task automatic run_r1(input logic [W-1:0] v, input logic [W-1:0] exp, input string tag);
    in_state1 = v;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check({tag, "_busy"}, W'(busy1), W'(1));
    check({tag, "_ov_early"}, W'(out_valid1), W'(0));
    @(posedge clk); #1;
    check({tag, "_busy_end"}, W'(busy1), W'(0));
    check({tag, "_ov"}, W'(out_valid1), W'(1));
    check({tag, "_state"}, out_state1, exp);
    @(posedge clk); #1;
    check({tag, "_ready_back"}, W'(in_ready1), W'(1));
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] pre;
    logic [W-1:0] ex;
    logic [7:0]   lf_exp [4];
    int           acc [4];
    int           n_sent;
    int           n;

    lf_exp = '{8'h75, 8'h6A, 8'h54, 8'h29};
    n_sent = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_out_state", out_state, W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-round instance: pre-P-layer nibbles for an all-zero input.
    for (int k = 0; k < 40; k++) begin
      pre[4*k +: 4] = (k == 0) ? 4'h1 : (k == 1) ? 4'hF : (k == 38) ? 4'h3 : (k == 39) ? 4'h8 : 4'hE;
    end
    run_r1(W'(0), player(pre), "r1_zero");
    check("r1_model_agree", ref_perm(W'(0), 1), player(pre));
    v = rand_vec();
    run_r1(v, ref_perm(v, 1), "r1_rand");

    // LFSR trace through the first rounds of an all-zero input.
    out_ready = 1'b1;
    send(W'(0), 1'b0);
    n_sent++;
    for (int i = 0; i < 4; i++) begin
      check("lfsr_trace", W'(dut.lfsr), W'(lf_exp[i]));
      @(posedge clk); #1;
    end
    drain();

    // Random full permutations.
    for (int i = 0; i < 28; i++) begin
      send(rand_vec(), 1'b0);
      n_sent++;
      drain();
    end

    // Backpressure in DONE with in_valid pulses that must be ignored.
    out_ready = 1'b0;
    v = rand_vec();
    ex = ref_perm(v, NR);
    send(v, 1'b0);
    n_sent++;
    n = 0;
    while (!out_valid && n < int'(TMO)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= int'(TMO)) check("bp_wait_timeout", W'(0), W'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_out_state", out_state, ex);
      check("bp_in_ready", W'(in_ready), W'(0));
      in_valid = (i % 2 == 0);
      in_state = ~v;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Abort at round 40 with an asynchronous reset, then a fresh run.
    send(rand_vec(), 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_busy_before", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_out_state", out_state, W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(rand_vec(), 1'b0);
    n_sent++;
    drain();

    // Back-to-back with both handshakes held high.
    for (int i = 0; i < 4; i++) begin
      send(rand_vec(), 1'b1);
      n_sent++;
      acc[i] = cyc;
      if (i > 0) check("b2b_gap", W'(acc[i] - acc[i-1]), W'(NR + 2));
    end
    in_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("result_count", W'(n_out), W'(n_sent));
    check("final_idle", W'(in_ready), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
